// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and defaults for the psum drain path.
// Holds the partial-sum width, the FIFO depth default and the drain FSM encoding.
package cnn_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIGN   = 3'd1,
    COLLECT = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } drain_state_t;

endpackage

// File: rtl/psum_deskew.sv
// Per-lane delay lines: lane c is delayed (col-1-c) cycles so a diagonal wavefront lines up.
// Latency: col-1 cycles for lane 0 down to 0 for the last lane; no backpressure (free-running).
module psum_deskew #(
  parameter int col    = 32,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [col*DATA_W-1:0] psum_in,
  output logic [col*DATA_W-1:0] aligned
);

  for (genvar c = 0; c < col; c++) begin : g_lane
    localparam int D = col - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*DATA_W +: DATA_W] = psum_in[c*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] sr [D];
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= psum_in[c*DATA_W +: DATA_W];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[c*DATA_W +: DATA_W] = sr[D-1];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered write and a combinational read port.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy drops only when full and no pop is happening this cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign rd_vld = (count != '0);
  // A pop frees the head slot in the same edge, so full-with-pop still accepts.
  assign wr_rdy = (count != (PW+1)'(DEPTH)) || rd_rdy;
  assign wr_en  = wr_vld && wr_rdy;
  assign rd_en  = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      count <= count + (PW+1)'(1);
      else if (rd_en && !wr_en) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains skewed systolic-array partial sums into aligned, indexed rows (DRAIN_RELU_EN clamps negatives).
// Latency: row r leaves at T+r+col after the conv_finish rising edge; one registered FIFO stage.
// Backpressure: out_ready stalls the FIFO; a push into a full FIFO drops the row and sets err_overflow.
module psum_drain_ctrl
  import cnn_pkg::*;
#(
  parameter int col        = 32,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  conv_finish,
  input  logic [5:0]            out_rows,
  input  logic [col*DATA_W-1:0] psum_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [col*DATA_W-1:0] out_data,
  output logic [5:0]            out_row_idx,
  output logic                  drain_done,
  output logic                  err_overflow
);
  localparam int ROW_W = col * DATA_W;
  localparam int AW    = $clog2(col);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(col - 2);

  drain_state_t state, nxt;

  logic             cf_q;
  logic             rise;
  logic [5:0]       rows_q;
  logic [5:0]       row_cnt;
  logic [AW-1:0]    align_cnt;
  logic             push;
  logic             wr_rdy;
  logic             rd_vld;
  logic [ROW_W-1:0] aligned;
  logic [ROW_W-1:0] wr_dat;
  logic [ROW_W+5:0] rd_dat;

  assign rise = conv_finish && !cf_q;

  psum_deskew #(
    .col    (col),
    .DATA_W (DATA_W)
  ) u_deskew (
    .clk     (clk),
    .nrst    (nrst),
    .psum_in (psum_in),
    .aligned (aligned)
  );

  for (genvar c = 0; c < col; c++) begin : g_wr
`ifdef DRAIN_RELU_EN
    assign wr_dat[c*DATA_W +: DATA_W] =
      aligned[c*DATA_W + DATA_W - 1] ? '0 : aligned[c*DATA_W +: DATA_W];
`else
    assign wr_dat[c*DATA_W +: DATA_W] = aligned[c*DATA_W +: DATA_W];
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= nxt;
  end

  // The edge cycle counts as the first of the col-1 alignment cycles, so ALIGN
  // lasts col-2 cycles and COLLECT starts exactly when row 0 is aligned.
  always_comb begin
    nxt  = state;
    push = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (out_rows == 6'd0) nxt = DONE;
          else if (col == 2)    nxt = COLLECT;
          else                  nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (align_cnt == ALIGN_LAST) nxt = COLLECT;
      end
      COLLECT: begin
        push = 1'b1;
        if (row_cnt == rows_q - 6'd1) nxt = FLUSH;
      end
      FLUSH: begin
        if (!rd_vld) nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cf_q         <= 1'b0;
      rows_q       <= '0;
      row_cnt      <= '0;
      align_cnt    <= '0;
      err_overflow <= 1'b0;
    end else begin
      cf_q <= conv_finish;
      if (state == IDLE && rise) begin
        rows_q    <= out_rows;
        row_cnt   <= '0;
        align_cnt <= AW'(1);
      end
      if (state == ALIGN) align_cnt <= align_cnt + AW'(1);
      // The row counter advances even when the row is dropped.
      if (push) row_cnt <= row_cnt + 6'd1;
      if (push && !wr_rdy) err_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ROW_W + 6),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nrst   (nrst),
    .wr_vld (push),
    .wr_rdy (wr_rdy),
    .wr_dat ({row_cnt, wr_dat}),
    .rd_vld (rd_vld),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat)
  );

  assign out_valid   = rd_vld;
  assign out_data    = rd_vld ? rd_dat[ROW_W-1:0] : '0;
  assign out_row_idx = rd_vld ? rd_dat[ROW_W +: 6] : '0;
  assign drain_done  = (state == DONE);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl with col=4, DATA_W=16, FIFO_DEPTH=4.
module tb_psum_drain_ctrl;
  localparam int COL = 4;
  localparam int DW  = 16;

  logic              clk;
  logic              nrst;
  logic              conv_finish;
  logic [5:0]        out_rows;
  logic [COL*DW-1:0] psum_in;
  logic              out_ready;
  logic              out_valid;
  logic [COL*DW-1:0] out_data;
  logic [5:0]        out_row_idx;
  logic              drain_done;
  logic              err_overflow;

  int checks   = 0;
  int failures = 0;
  int rel      = 100;
  int nrows    = 0;
  bit hold_cf  = 0;
  bit use_fixed = 0;
  logic [DW-1:0] fixed_val = '0;

  psum_drain_ctrl #(.col(COL), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .conv_finish  (conv_finish),
    .out_rows     (out_rows),
    .psum_in      (psum_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_row_idx  (out_row_idx),
    .drain_done   (drain_done),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [COL*DW-1:0] exp_row(int r);
    logic [COL*DW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*DW +: DW] = DW'(10*r + c);
    return v;
  endfunction

  task automatic drive_psum();
    logic [COL*DW-1:0] v;
    int r;
    for (int c = 0; c < COL; c++) begin
      r = rel - c;
      if (r >= 0 && r < nrows) v[c*DW +: DW] = use_fixed ? fixed_val : DW'(10*r + c);
      else                     v[c*DW +: DW] = 16'h7777;
    end
    psum_in = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    if (!hold_cf && rel == 1) conv_finish = 1'b0;
    drive_psum();
    #1;
  endtask

  task automatic start(int rows);
    nrows       = rows;
    out_rows    = 6'(rows);
    rel         = 0;
    conv_finish = 1'b1;
    drive_psum();
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", drain_done); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_overflow); end
    checks++; if (out_row_idx !== 6'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", out_row_idx); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
    step(); step();
    nrst = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    logic exp_v;
    out_ready = 1'b1;
    start(3);
    for (int t = 1; t <= 10; t++) begin
      step();
      exp_v = (t >= 4 && t <= 6);
      checks++;
      if (out_valid !== exp_v) begin failures++; $display("FAIL basic_valid t=%0d got=%b exp=%b", t, out_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if (out_data !== exp_row(t-4)) begin failures++; $display("FAIL basic_data t=%0d got=%h exp=%h", t, out_data, exp_row(t-4)); end
        checks++;
        if (out_row_idx !== 6'(t-4)) begin failures++; $display("FAIL basic_idx t=%0d got=%0d exp=%0d", t, out_row_idx, t-4); end
      end
      checks++;
      if (drain_done !== (t == 8)) begin failures++; $display("FAIL basic_done t=%0d got=%b exp=%b", t, drain_done, (t == 8)); end
    end
  endtask

  task automatic test_overflow();
    int done_seen = 0;
    out_ready = 1'b0;
    start(6);
    for (int t = 1; t <= 14; t++) begin
      step();
      if (drain_done) done_seen++;
      if (t == 7) begin
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_err_early got=%b exp=0", err_overflow); end
      end
      if (t == 8) begin
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_err_set got=%b exp=1", err_overflow); end
      end
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL ovf_no_done got=%0d exp=0", done_seen); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_hold_valid got=%b exp=1", out_valid); end
    checks++; if (out_row_idx !== 6'd0) begin failures++; $display("FAIL ovf_hold_idx got=%0d exp=0", out_row_idx); end
    checks++; if (out_data !== exp_row(0)) begin failures++; $display("FAIL ovf_hold_data got=%h exp=%h", out_data, exp_row(0)); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_drain_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (out_row_idx !== 6'(k)) begin failures++; $display("FAIL ovf_drain_idx k=%0d got=%0d exp=%0d", k, out_row_idx, k); end
      checks++; if (out_data !== exp_row(k)) begin failures++; $display("FAIL ovf_drain_data k=%0d got=%h exp=%h", k, out_data, exp_row(k)); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL ovf_done_early got=%b exp=0", drain_done); end
    step();
    checks++; if (drain_done !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b exp=1", drain_done); end
    step();
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", err_overflow); end
    nrst = 1'b0;
    #1;
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", err_overflow); end
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_zero_rows();
    out_ready = 1'b1;
    start(0);
    step();
    checks++; if (drain_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", drain_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", drain_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_valid2 got=%b exp=0", out_valid); end
  endtask

  task automatic test_held_high();
    int dones = 0;
    int xfers = 0;
    out_ready = 1'b1;
    hold_cf   = 1'b1;
    start(2);
    for (int t = 1; t <= 100; t++) begin
      step();
      if (drain_done) dones++;
      if (out_valid && out_ready) xfers++;
    end
    hold_cf     = 1'b0;
    conv_finish = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (drain_done) dones++;
      if (out_valid && out_ready) xfers++;
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL held_dones got=%0d exp=1", dones); end
    checks++; if (xfers != 2) begin failures++; $display("FAIL held_xfers got=%0d exp=2", xfers); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int valids = 0;
    out_ready = 1'b1;
    start(3);
    for (int t = 1; t <= 5; t++) step();
    nrst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL mid_data got=%h exp=0", out_data); end
    checks++; if (out_row_idx !== 6'd0) begin failures++; $display("FAIL mid_idx got=%0d exp=0", out_row_idx); end
    checks++; if (drain_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", drain_done); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err_overflow); end
    step(); step();
    nrst = 1'b1;
    for (int t = 0; t < 15; t++) begin
      step();
      if (drain_done) dones++;
      if (out_valid) valids++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    checks++; if (valids != 0) begin failures++; $display("FAIL mid_no_valid got=%0d exp=0", valids); end
    test_basic();
  endtask

  task automatic test_relu();
    logic [COL*DW-1:0] exp_v;
    use_fixed = 1'b1;
    fixed_val = 16'hFFF9;
`ifdef DRAIN_RELU_EN
    exp_v = '0;
`else
    exp_v = {COL{16'hFFF9}};
`endif
    out_ready = 1'b1;
    start(1);
    for (int t = 1; t <= 8; t++) begin
      step();
      if (t == 4) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL relu_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_v) begin failures++; $display("FAIL relu_data got=%h exp=%h", out_data, exp_v); end
      end
      if (t == 6) begin
        checks++; if (drain_done !== 1'b1) begin failures++; $display("FAIL relu_done got=%b exp=1", drain_done); end
      end
    end
    use_fixed = 1'b0;
  endtask

  initial begin
    nrst        = 1'b0;
    conv_finish = 1'b0;
    out_rows    = 6'd0;
    out_ready   = 1'b1;
    psum_in     = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero_rows();
    test_held_high();
    test_reset_mid();
    test_relu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
